sram_dp_march_bist: RTL and testbench
=====================================

// Module: sram_dp_march_bist
// PURPOSE
//  March C- BIST initiator for port A of the 64x36 dual-port SRAM wrapper; drives MEA/WEA/ADRA/DA, checks QA.
//  Sits beside the wrapper in the mem_wrap hierarchy; the SoC test controller starts it and reads back pass/fail.
//  Port B is untouched; the system must keep port B idle (MEB=0) while bist_busy=1.
// PARAMETERS
//  ADDR_W      6        SRAM address width; DEPTH = 2**ADDR_W = 64
//  DATA_W      36       SRAM data width
//  BACKGROUND  36'h0    data pattern used as "0"; "1" = ~BACKGROUND
// PORTS
//  CLKA        in   1       clock (same clock as SRAM port A)
//  reset_n     in   1       asynchronous, active-low reset
//  scan_mode   in   1       1 = scan; aborts and blocks BIST
//  bist_start  in   1       single-cycle start request
//  bist_busy   out  1       1 while a march run is in progress
//  bist_done   out  1       1 from run completion until next start/reset/scan_mode
//  bist_fail   out  1       sticky: at least one read mismatch this run
//  fail_addr   out  ADDR_W  address of first mismatch
//  fail_elem   out  3       march element (1..5) of first mismatch
//  MEA         out  1       SRAM port A enable
//  WEA         out  1       SRAM port A write enable (valid with MEA)
//  ADRA        out  ADDR_W  SRAM port A address
//  DA          out  DATA_W  SRAM port A write data
//  QA          in   DATA_W  SRAM port A read data
// BEHAVIOUR
//  - Reset: reset_n=0 -> all outputs 0 immediately (MEA,WEA,ADRA,DA,busy,done,fail,fail_addr,fail_elem); FSM=IDLE.
//  - All outputs registered on CLKA. SRAM read latency 1: read issued in cycle t, QA valid cycle t+1.
//  - States: IDLE, M0..M5, FLUSH, DONE. Elements (0=BACKGROUND, 1=~BACKGROUND):
//    M0 up(w0)  M1 up(r0,w1)  M2 up(r1,w0)  M3 down(r0,w1)  M4 down(r1,w0)  M5 down(r0)
//  - up: addr 0..63; down: 63..0. r/w pairs take 2 cycles per addr (read then write same addr).
//  - Accesses back-to-back, MEA=1 every run cycle: 64+4*128+64 = 640 accesses (320 writes, 320 reads).
//  - IDLE/DONE + bist_start=1 (scan_mode=0) -> M0 at next edge E0; first access driven after E0.
//  - bist_start while busy: ignored. From DONE: restarts, clears done/fail/fail_addr/fail_elem at E0.
//  - Compare pipe: read issue registers {exp_data, addr, elem, valid}; next edge compares QA vs exp_data.
//  - Mismatch: bist_fail<=1; fail_addr/fail_elem loaded only on first mismatch of run. Run never aborts on fail.
//  - After last M5 read (addr 0) -> FLUSH (MEA=0) for final compare -> DONE; bist_done=1, busy=0 at edge E0+641.
//  - bist_busy=1 from E0 through FLUSH. MEA/WEA=0 in IDLE, FLUSH, DONE; ADRA/DA hold last value there.
//  - Element transitions: last address of element -> first address of next element next cycle, no gap.
//  - Address counter: ADDR_W-bit; up ends at 63, down ends at 0; no wrap used.
//  - scan_mode=1: FSM -> IDLE at next edge from any state; MEA=WEA=0, busy=done=0; fail regs retain;
//    bist_start ignored while scan_mode=1; compare of an in-flight read discarded.
//  - Reset mid-run: run abandoned, all outputs 0; new start runs full sequence.
// TESTING
//  1. Fault-free SRAM model, pulse start -> busy=1 after E0; 640 MEA cycles, 320 WEA; done at E0+641; fail=0.
//  2. SRAM bit 7 stuck-at-1 at addr 6'h15 -> fail=1, fail_addr=6'h15, fail_elem=1; done still at E0+641.
//  3. Decoder fault: addr 6'h3F aliases to 6'h00 (rd+wr) -> fail=1, fail_addr=6'h3F, fail_elem=1.
//  4. reset_n low at cycle 300 of run -> all outputs 0 at once; new start -> clean run, done at E0+641.
//  5. scan_mode=1 at cycle 100 -> MEA=0, busy=0 next edge; start pulse while scan_mode=1 -> no activity.
//  6. start pulsed mid-run -> ignored (done still E0+641); start in DONE after fail -> done/fail cleared, rerun.

Source files
------------

// File: rtl/sram_dp_march_bist.sv
// March C- BIST initiator for port A of the 64x36 dual-port SRAM wrapper.
// Sequences the six march elements back to back and records the first read mismatch.
module sram_dp_march_bist #(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 36,
  parameter logic [DATA_W-1:0] BACKGROUND = '0
) (
  input  logic              CLKA,
  input  logic              reset_n,
  input  logic              scan_mode,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic              MEA,
  output logic              WEA,
  output logic [ADDR_W-1:0] ADRA,
  output logic [DATA_W-1:0] DA,
  input  logic [DATA_W-1:0] QA
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;  // 1 = write half of a read/write pair
  logic              start_ok;
  logic              last_addr, pair_elem, active_d;
  logic [ADDR_W-1:0] step_addr;
  logic              mea_d, wea_d, busy_d, done_d;
  logic [ADDR_W-1:0] adra_d;
  logic [DATA_W-1:0] da_d;

  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_exp_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [2:0]        rd_elem_q;
  logic              mismatch;

  function automatic logic elem_up(state_t s);
    return (s == S_M0) || (s == S_M1) || (s == S_M2);
  endfunction

  function automatic state_t next_elem(state_t s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      S_M5:    return S_FLUSH;
      default: return S_IDLE;
    endcase
  endfunction

  function automatic logic [2:0] elem_num(state_t s);
    case (s)
      S_M1:    return 3'd1;
      S_M2:    return 3'd2;
      S_M3:    return 3'd3;
      S_M4:    return 3'd4;
      S_M5:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Selects "1" data (~BACKGROUND) for the access; reads carry their expected value on DA.
  function automatic logic data_one(state_t s, logic we);
    case (s)
      S_M1, S_M3: return we;
      S_M2, S_M4: return !we;
      default:    return 1'b0;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    phase_d   = 1'b0;
    start_ok  = 1'b0;
    pair_elem = (state_q == S_M1) || (state_q == S_M2) ||
                (state_q == S_M3) || (state_q == S_M4);
    last_addr = elem_up(state_q) ? (addr_q == ADDR_MAX) : (addr_q == '0);
    step_addr = elem_up(state_q) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);

    if (scan_mode) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bist_start) begin
            start_ok = 1'b1;
            state_d  = S_M0;
            addr_d   = '0;
          end
        end
        S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
          if (pair_elem && !phase_q) begin
            phase_d = 1'b1;
          end else if (last_addr) begin
            state_d = next_elem(state_q);
            if (state_d != S_FLUSH) addr_d = elem_up(state_d) ? '0 : ADDR_MAX;
          end else begin
            addr_d = step_addr;
          end
        end
        S_FLUSH: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    active_d = (state_d == S_M0) || (state_d == S_M1) || (state_d == S_M2) ||
               (state_d == S_M3) || (state_d == S_M4) || (state_d == S_M5);
    mea_d    = active_d;
    wea_d    = active_d && ((state_d == S_M0) || (pair_elem_next(state_d) && phase_d));
    adra_d   = active_d ? addr_d : ADRA;
    da_d     = active_d ? (data_one(state_d, wea_d) ? ~BACKGROUND : BACKGROUND) : DA;
    busy_d   = active_d || (state_d == S_FLUSH);
    done_d   = (state_d == S_DONE);
  end

  function automatic logic pair_elem_next(state_t s);
    return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLKA or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      MEA       <= 1'b0;
      WEA       <= 1'b0;
      ADRA      <= '0;
      DA        <= '0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      phase_q   <= phase_d;
      MEA       <= mea_d;
      WEA       <= wea_d;
      ADRA      <= adra_d;
      DA        <= da_d;
      bist_busy <= busy_d;
      bist_done <= done_d;
    end
  end

  // Read issued on the port is captured when the SRAM samples it; QA is compared one edge later.
  assign mismatch = rd_valid_q && (QA != rd_exp_q);

  always_ff @(posedge CLKA or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_exp_q   <= '0;
      rd_addr_q  <= '0;
      rd_elem_q  <= '0;
      bist_fail  <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else begin
      rd_valid_q <= MEA && !WEA && !scan_mode;
      rd_exp_q   <= DA;
      rd_addr_q  <= ADRA;
      rd_elem_q  <= elem_num(state_q);
      if (start_ok) begin
        bist_fail <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch && !scan_mode) begin
        bist_fail <= 1'b1;
        if (!bist_fail) begin
          fail_addr <= rd_addr_q;
          fail_elem <= rd_elem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_dp_march_bist.sv
// Bench for sram_dp_march_bist: faulty SRAM model on port A, March C- reference model,
// fixed scenario table plus randomized fault runs.
module tb_sram_dp_march_bist;
  localparam int            AW = 6;
  localparam int            DW = 36;
  localparam logic [DW-1:0] BG = '0;

  logic          CLKA = 1'b0;
  logic          reset_n = 1'b0;
  logic          scan_mode = 1'b0;
  logic          bist_start = 1'b0;
  logic          bist_busy, bist_done, bist_fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic          MEA, WEA;
  logic [AW-1:0] ADRA;
  logic [DW-1:0] DA;
  logic [DW-1:0] QA = '0;

  sram_dp_march_bist #(.ADDR_W(AW), .DATA_W(DW), .BACKGROUND(BG)) dut (
    .CLKA(CLKA), .reset_n(reset_n), .scan_mode(scan_mode), .bist_start(bist_start),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem),
    .MEA(MEA), .WEA(WEA), .ADRA(ADRA), .DA(DA), .QA(QA)
  );

  always #5 CLKA = ~CLKA;

  // Fault environment: 0 none, 1 cell bit stuck, 2 address f_addr aliases to f_alias_to.
  int            f_kind = 0;
  logic [AW-1:0] f_addr = '0;
  logic [AW-1:0] f_alias_to = '0;
  int            f_bit = 0;
  logic          f_val = 1'b0;
  logic [DW-1:0] mem [64];
  logic [DW-1:0] rm  [64];

  function automatic logic [AW-1:0] map_addr(logic [AW-1:0] a);
    return (f_kind == 2 && a == f_addr) ? f_alias_to : a;
  endfunction

  function automatic logic [DW-1:0] stick(logic [AW-1:0] phys, logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (f_kind == 1 && phys == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge CLKA) begin
    if (MEA) begin
      if (WEA) mem[map_addr(ADRA)] <= DA;
      else     QA <= stick(map_addr(ADRA), mem[map_addr(ADRA)]);
    end
  end

  // Reference: March C- written out as a flat list of operations.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    elem;
  } op_t;
  op_t ops[$];

  task automatic build_ops();
    logic [AW-1:0] a;
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 64; i++) begin
        a = (e < 3) ? AW'(i) : AW'(63 - i);
        if (e != 0) ops.push_back('{1'b0, a, ((e == 2 || e == 4) ? ~BG : BG), 3'(e)});
        if (e != 5) ops.push_back('{1'b1, a, ((e == 1 || e == 3) ? ~BG : BG), 3'(e)});
      end
    end
  endtask

  task automatic ref_eval(output bit ef, output logic [AW-1:0] ea, output logic [2:0] ee);
    logic [AW-1:0] p;
    for (int i = 0; i < 64; i++) rm[i] = mem[i];
    ef = 1'b0; ea = '0; ee = '0;
    foreach (ops[k]) begin
      p = map_addr(ops[k].addr);
      if (ops[k].we) rm[p] = ops[k].data;
      else if (stick(p, rm[p]) !== ops[k].data && !ef) begin
        ef = 1'b1; ea = ops[k].addr; ee = ops[k].elem;
      end
    end
  endtask

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One full run; checks the access trace, counts, timing and final verdict.
  task automatic run_bist(input string tag, input bit ef, input logic [AW-1:0] ea,
                          input logic [2:0] ee, input int mid_start);
    int n_mea, n_wea, seq_err, done_at, idx;
    n_mea = 0; n_wea = 0; seq_err = 0; done_at = -1; idx = 0;
    @(negedge CLKA); bist_start = 1'b1;
    @(posedge CLKA); #1; bist_start = 1'b0;
    check({tag, ":start_flags"}, {61'd0, bist_busy, bist_done, bist_fail}, 64'b100);
    check({tag, ":start_cleared"}, {55'd0, fail_addr, fail_elem}, 64'd0);
    for (int t = 0; t <= 700; t++) begin
      bist_start = (t == mid_start);
      if (MEA) begin
        n_mea++;
        if (WEA) n_wea++;
        if (idx >= ops.size()) seq_err++;
        else if (WEA !== ops[idx].we || ADRA !== ops[idx].addr ||
                 (WEA && DA !== ops[idx].data)) seq_err++;
        idx++;
      end
      if (t == 640) check({tag, ":flush"}, {62'd0, bist_busy, MEA}, 64'b10);
      if (bist_done) begin
        done_at = t;
        break;
      end
      @(posedge CLKA); #1;
    end
    bist_start = 1'b0;
    check({tag, ":mea_cycles"}, 64'(n_mea), 64'd640);
    check({tag, ":wea_cycles"}, 64'(n_wea), 64'd320);
    check({tag, ":seq_errors"}, 64'(seq_err), 64'd0);
    check({tag, ":done_edge"}, 64'(done_at), 64'd641);
    check({tag, ":busy_at_done"}, {63'd0, bist_busy}, 64'd0);
    check({tag, ":fail"}, {63'd0, bist_fail}, {63'd0, ef});
    if (ef) check({tag, ":fail_loc"}, {55'd0, fail_addr, fail_elem}, {55'd0, ea, ee});
  endtask

  typedef struct {
    string         tag;
    int            kind;
    logic [AW-1:0] addr;
    logic [AW-1:0] alias_to;
    int            bit_n;
    logic          val;
    int            mid_start;
    bit            ef;
    logic [AW-1:0] ea;
    logic [2:0]    ee;
  } vec_t;
  vec_t vecs[3];

  initial begin
    bit            ef;
    logic [AW-1:0] ea;
    logic [2:0]    ee;
    bit            activity;

    vecs[0] = '{"stuck15", 1, 6'h15, 6'h00, 7, 1'b1, -1, 1'b1, 6'h15, 3'd1};
    vecs[1] = '{"alias3f", 2, 6'h3F, 6'h00, 0, 1'b0, -1, 1'b1, 6'h3F, 3'd1};
    vecs[2] = '{"clean",   0, 6'h00, 6'h00, 0, 1'b0, 200, 1'b0, 6'h00, 3'd0};
    build_ops();

    repeat (3) @(posedge CLKA);
    #1;
    check("reset_state", {8'd0, bist_busy, bist_done, bist_fail, fail_addr, fail_elem,
                          MEA, WEA, ADRA, DA}, 64'd0);
    @(negedge CLKA); reset_n = 1'b1;
    repeat (2) @(posedge CLKA);
    #1;
    check("idle_quiet", {61'd0, MEA, bist_busy, bist_done}, 64'd0);

    for (int v = 0; v < 3; v++) begin
      f_kind = vecs[v].kind; f_addr = vecs[v].addr; f_alias_to = vecs[v].alias_to;
      f_bit = vecs[v].bit_n; f_val = vecs[v].val;
      run_bist(vecs[v].tag, vecs[v].ef, vecs[v].ea, vecs[v].ee, vecs[v].mid_start);
    end

    // scan_mode abort at cycle 100 after an early failure; fail registers must survive.
    f_kind = 1; f_addr = 6'h02; f_bit = 0; f_val = 1'b1;
    @(negedge CLKA); bist_start = 1'b1;
    @(posedge CLKA); #1; bist_start = 1'b0;
    repeat (100) @(posedge CLKA);
    #1; scan_mode = 1'b1;
    @(posedge CLKA); #1;
    check("scan_abort", {60'd0, MEA, WEA, bist_busy, bist_done}, 64'd0);
    check("scan_fail_kept", {54'd0, bist_fail, fail_addr, fail_elem}, {54'd0, 1'b1, 6'h02, 3'd1});
    @(negedge CLKA); bist_start = 1'b1;
    @(posedge CLKA); #1; bist_start = 1'b0;
    activity = 1'b0;
    repeat (5) begin
      if (MEA || bist_busy || bist_done) activity = 1'b1;
      @(posedge CLKA); #1;
    end
    check("scan_blocks_start", {63'd0, activity}, 64'd0);
    scan_mode = 1'b0;
    repeat (3) @(posedge CLKA);
    #1;
    check("after_scan_idle", {60'd0, MEA, bist_busy, bist_done, bist_fail}, 64'b0001);

    // Reset in the middle of a failing run.
    @(negedge CLKA); bist_start = 1'b1;
    @(posedge CLKA); #1; bist_start = 1'b0;
    repeat (300) @(posedge CLKA);
    #2; reset_n = 1'b0;
    #1;
    check("midrun_reset", {8'd0, bist_busy, bist_done, bist_fail, fail_addr, fail_elem,
                           MEA, WEA, ADRA, DA}, 64'd0);
    @(negedge CLKA); reset_n = 1'b1;
    f_kind = 0;
    run_bist("post_reset", 1'b0, '0, '0, -1);

    // Randomized faults against the reference model.
    for (int r = 0; r < 5; r++) begin
      f_kind = int'($urandom_range(0, 2));
      f_addr = AW'($urandom_range(0, 63));
      f_alias_to = AW'(f_addr + AW'($urandom_range(1, 63)));
      f_bit  = int'($urandom_range(0, DW - 1));
      f_val  = 1'($urandom_range(0, 1));
      ref_eval(ef, ea, ee);
      run_bist($sformatf("rand%0d_k%0d", r, f_kind), ef, ea, ee, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
